// File: rtl/sched_write_pkg.sv
// Shared types and helpers for the delayed-commit register bank.
package sched_write_pkg;

  // Slot record field widths. These are the largest supported configuration;
  // narrower instances zero-extend into them and synthesis prunes the
  // constant upper bits.
  localparam int SLOT_AW = 8;   // address bits   (NREGS <= 256)
  localparam int SLOT_DW = 64;  // data bits      (WIDTH <= 64)
  localparam int SLOT_CW = 8;   // countdown bits (MAX_DELAY <= 255)
  localparam int SLOT_SW = 32;  // stamp bits     (TSW <= 32)

  // Width of a field able to index n items, never narrower than 1 bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] addr;
    logic [SLOT_DW-1:0] data;
    logic [SLOT_CW-1:0] count;  // edges left until commit; commits when 1
    logic [SLOT_SW-1:0] stamp;  // cycle counter value at issue
  } slot_t;

  // True when stamp a was issued at or after stamp b, in a tsw-bit
  // wrapping time base: (a - b) mod 2^tsw lies in the lower half-range.
  function automatic logic stamp_newer(input logic [SLOT_SW-1:0] a,
                                       input logic [SLOT_SW-1:0] b,
                                       input int tsw);
    logic [SLOT_SW-1:0] diff;
    logic [SLOT_SW-1:0] half;
    diff = a - b;
    if (tsw < SLOT_SW) diff = diff & ((SLOT_SW'(1) << tsw) - SLOT_SW'(1));
    half = SLOT_SW'(1) << (tsw - 1);
    return diff < half;
  endfunction

endpackage

// File: rtl/sched_write_slot.sv
// One pending-write entry: loads a request, counts down, reports commit,
// and is discarded by flush.
module sched_write_slot
  import sched_write_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,       // only asserted while this slot is free
  input  slot_t i_load_slot,
  input  logic  i_flush,
  output slot_t o_slot,
  output logic  o_commit
);

  slot_t r_slot;

  assign o_slot   = r_slot;
  // A flushed entry never commits, even on its due edge.
  assign o_commit = r_slot.valid && (r_slot.count == SLOT_CW'(1)) && !i_flush;

  // Load, flush, or count down toward the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot <= i_load_slot;
    end else if (i_flush) begin
      r_slot.valid <= 1'b0;
    end else if (r_slot.valid) begin
      if (r_slot.count == SLOT_CW'(1)) r_slot.valid <= 1'b0;
      else                             r_slot.count <= r_slot.count - SLOT_CW'(1);
    end
  end

endmodule

// File: rtl/sched_write_bank.sv
// Register bank whose writes commit a programmable number of edges after
// acceptance. Last-issued write wins on same-address collisions.
module sched_write_bank
  import sched_write_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NREGS     = 4,
  parameter int               MAX_DELAY = 7,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               TSW       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(NREGS)-1:0]       wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [$clog2(MAX_DELAY+1)-1:0] wr_delay,
  input  logic                           flush,
  input  logic [$clog2(NREGS)-1:0]       rd_addr,
  output logic [WIDTH-1:0]               rd_data,
  output logic [NREGS-1:0]               commit_mask,
  output logic [$clog2(DEPTH+1)-1:0]     pending,
  output logic [TSW-1:0]                 now
);

  localparam int AW  = cw(NREGS);
  localparam int DLW = cw(MAX_DELAY + 1);
  localparam int PW  = cw(DEPTH + 1);

  logic [NREGS-1:0][WIDTH-1:0] r_regs;
  logic [NREGS-1:0]            r_commit_mask;
  logic [PW-1:0]               r_pending;
  logic [TSW-1:0]              r_now;

  logic [DLW-1:0]              w_delay;
  logic                        w_accept, w_imm, w_enq;
  slot_t                       w_new_slot;
  slot_t                       w_slot [DEPTH];
  logic [DEPTH-1:0]            w_slot_commit;
  logic [DEPTH-1:0]            w_slot_load;
  logic [DEPTH-1:0]            w_unused_slot;
  logic [NREGS-1:0]            w_we;
  logic [NREGS-1:0][WIDTH-1:0] w_wd;
  logic [PW-1:0]               w_pending_nxt;

  // Backpressure depends only on current occupancy, so a slot freed at an
  // edge becomes usable from the following cycle.
  assign wr_ready    = (r_pending < PW'(DEPTH));
  assign w_accept    = wr_valid && wr_ready;
  assign w_imm       = w_accept && (w_delay == '0);
  assign w_enq       = w_accept && (w_delay != '0);

  assign rd_data     = r_regs[rd_addr];
  assign commit_mask = r_commit_mask;
  assign pending     = r_pending;
  assign now         = r_now;

  // Clamp the requested delay to the supported maximum.
  always_comb begin
    w_delay = wr_delay;
    if (int'(wr_delay) > MAX_DELAY) w_delay = DLW'(MAX_DELAY);
  end

  // Slot image for an enqueued request, stamped with the current cycle.
  always_comb begin
    w_new_slot       = '0;
    w_new_slot.valid = 1'b1;
    w_new_slot.addr  = SLOT_AW'(wr_addr);
    w_new_slot.data  = SLOT_DW'(wr_data);
    w_new_slot.count = SLOT_CW'(w_delay);
    w_new_slot.stamp = SLOT_SW'(r_now);
  end

  // Allocator: the lowest slot that is free before this edge.
  always_comb begin
    logic found;
    found       = 1'b0;
    w_slot_load = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && !w_slot[i].valid) begin
        w_slot_load[i] = w_enq;
        found          = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    sched_write_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_slot_load[i]),
      .i_load_slot (w_new_slot),
      .i_flush     (flush),
      .o_slot      (w_slot[i]),
      .o_commit    (w_slot_commit[i])
    );
    // Only the configured low bits of each field are consumed.
    assign w_unused_slot[i] = ^w_slot[i];
  end

  // Per-register winner: newest-stamped due slot, overridden by an
  // incoming delay-0 write to the same address.
  always_comb begin
    logic [SLOT_SW-1:0] best;
    best = '0;
    w_we = '0;
    w_wd = r_regs;
    for (int r = 0; r < NREGS; r++) begin
      best = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_slot_commit[i] && (w_slot[i].addr == SLOT_AW'(r)) &&
            (!w_we[r] || stamp_newer(w_slot[i].stamp, best, TSW))) begin
          w_we[r] = 1'b1;
          w_wd[r] = w_slot[i].data[WIDTH-1:0];
          best    = w_slot[i].stamp;
        end
      end
      if (w_imm && (wr_addr == AW'(r))) begin
        w_we[r] = 1'b1;
        w_wd[r] = wr_data;
      end
    end
  end

  // Post-edge occupancy: flush drops everything old, commits free their
  // slots, and an enqueue adds one.
  always_comb begin
    w_pending_nxt = r_pending;
    if (flush) begin
      w_pending_nxt = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_slot_commit[i]) w_pending_nxt = w_pending_nxt - PW'(1);
    end
    if (w_enq) w_pending_nxt = w_pending_nxt + PW'(1);
  end

  // Committed state, commit mask, occupancy and free-running counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs        <= {NREGS{RESET_VAL}};
      r_commit_mask <= '0;
      r_pending     <= '0;
      r_now         <= '0;
    end else begin
      r_regs        <= w_wd;
      r_commit_mask <= w_we;
      r_pending     <= w_pending_nxt;
      r_now         <= r_now + TSW'(1);
    end
  end

endmodule

// File: tb/tb_sched_write_bank.sv
// Self-checking bench for sched_write_bank: directed vector table,
// multi-cycle corner sequences, and random traffic against a queue model.
module tb_sched_write_bank;

  localparam int WIDTH = 8, NREGS = 4, MAX_DELAY = 7, DEPTH = 4, TSW = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_valid = 1'b0, flush = 1'b0;
  logic [1:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] wr_delay = '0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic [3:0] commit_mask;
  logic [2:0] pending;
  logic [15:0] now;

  sched_write_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .MAX_DELAY(MAX_DELAY),
                     .DEPTH(DEPTH), .RESET_VAL(8'h00), .TSW(TSW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_delay(wr_delay), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data), .commit_mask(commit_mask),
    .pending(pending), .now(now)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: pending writes as (addr, data, absolute due edge) in
  // issue order; applying due entries in order makes the latest issue win.
  typedef struct { int addr; int data; int due; } pw_t;
  pw_t mq[$];
  int  m_regs [NREGS];
  int  m_mask;
  int  m_cyc;

  typedef struct {
    bit v; int addr; int data; int dly; bit fl;
    int e_pend; int e_mask; int rd; int e_rd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_regs[r]) m_regs[r] = 0;
    m_mask = 0;
    m_cyc  = 0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit  acc;
    int  d;
    pw_t keep[$];
    acc = wr_valid && (mq.size() < DEPTH);
    m_cyc++;
    m_mask = 0;
    if (flush) mq.delete();
    foreach (mq[i]) begin
      if (mq[i].due == m_cyc) begin
        m_regs[mq[i].addr] = mq[i].data;
        m_mask |= (1 << mq[i].addr);
      end else begin
        keep.push_back(mq[i]);
      end
    end
    mq = keep;
    if (acc) begin
      d = (int'(wr_delay) > MAX_DELAY) ? MAX_DELAY : int'(wr_delay);
      if (d == 0) begin
        m_regs[wr_addr] = int'(wr_data);
        m_mask |= (1 << wr_addr);
      end else begin
        mq.push_back('{int'(wr_addr), int'(wr_data), m_cyc + d});
      end
    end
  endtask

  // One clock: check ready, step model, take the edge, check all state.
  task automatic tick();
    chk("wr_ready", wr_ready, (mq.size() < DEPTH) ? 1 : 0);
    model_edge();
    @(posedge clk);
    #1;
    chk("pending", pending, mq.size());
    chk("commit_mask", commit_mask, m_mask);
    chk("now", now, m_cyc & 32'hFFFF);
    for (int r = 0; r < NREGS; r++) begin
      rd_addr = 2'(r);
      #1;
      chk("rd_data", rd_data, m_regs[r]);
    end
  endtask

  initial begin
    int s, acc_edge;

    // Hand-derived vectors from reset; row k is driven before edge k+1.
    tbl[0]  = '{1, 2, 'h11, 3, 0, 1, 'b0000, 2, 'h00};
    tbl[1]  = '{1, 2, 'h22, 2, 0, 2, 'b0000, 2, 'h00};
    tbl[2]  = '{1, 1, 'h05, 2, 0, 3, 'b0000, 1, 'h00};
    tbl[3]  = '{0, 0, 'h00, 0, 0, 1, 'b0100, 2, 'h22};
    tbl[4]  = '{0, 0, 'h00, 0, 0, 0, 'b0010, 1, 'h05};
    tbl[5]  = '{1, 0, 'h0A, 2, 0, 1, 'b0000, 0, 'h00};
    tbl[6]  = '{0, 0, 'h00, 0, 0, 1, 'b0000, 0, 'h00};
    tbl[7]  = '{1, 0, 'h0B, 0, 0, 0, 'b0001, 0, 'h0B};
    tbl[8]  = '{0, 0, 'h00, 0, 0, 0, 'b0000, 0, 'h0B};
    tbl[9]  = '{1, 1, 'h77, 1, 0, 1, 'b0000, 1, 'h05};
    tbl[10] = '{1, 3, 'h33, 1, 1, 1, 'b0000, 1, 'h05};
    tbl[11] = '{0, 0, 'h00, 0, 0, 0, 'b1000, 3, 'h33};

    // Reset state before any edge.
    model_reset();
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_now", now, 0);
    chk("rst_mask", commit_mask, 0);
    chk("rst_ready", wr_ready, 1);
    #2 rst_n = 1'b1;

    // Directed table.
    for (int k = 0; k < 12; k++) begin
      wr_valid = tbl[k].v;  wr_addr  = 2'(tbl[k].addr);
      wr_data  = 8'(tbl[k].data); wr_delay = 3'(tbl[k].dly);
      flush    = tbl[k].fl;
      tick();
      chk("tbl_pending", pending, tbl[k].e_pend);
      chk("tbl_mask", commit_mask, tbl[k].e_mask);
      rd_addr = 2'(tbl[k].rd);
      #1;
      chk("tbl_rd", rd_data, tbl[k].e_rd);
    end
    wr_valid = 0; flush = 0;

    // Fill every slot, then hold a fifth request until space appears.
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1; wr_addr = 2'(i); wr_data = 8'(8'h60 + i); wr_delay = 3'd7;
      tick();
    end
    s = m_cyc;
    wr_valid = 1; wr_addr = 2'd0; wr_data = 8'h99; wr_delay = 3'd1;
    chk("full_ready", wr_ready, 0);
    chk("full_pending", pending, DEPTH);
    acc_edge = -1;
    for (int n = 0; n < 20 && acc_edge < 0; n++) begin
      if (wr_ready) acc_edge = m_cyc + 1;
      tick();
    end
    wr_valid = 0;
    chk("held_accept_edge", acc_edge, s - (DEPTH - 1) + 8);
    for (int n = 0; n < 4; n++) tick();

    // Asynchronous reset with three slots outstanding.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 2'(i); wr_data = 8'(8'hC0 + i); wr_delay = 3'd7;
      tick();
    end
    wr_valid = 0;
    chk("pre_rst_pending", pending, 3);
    rst_n = 1'b0;
    #2;
    chk("midrst_pending", pending, 0);
    chk("midrst_now", now, 0);
    chk("midrst_mask", commit_mask, 0);
    for (int r = 0; r < NREGS; r++) begin
      rd_addr = 2'(r);
      #1;
      chk("midrst_reg", rd_data, 0);
    end
    model_reset();
    #1 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom);
      wr_delay = 3'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 19) == 0);
      tick();
    end
    wr_valid = 0; flush = 0;
    for (int n = 0; n < 10; n++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
